pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control unit for the 5-stage RISC-V core. It sequences the fetch-side pipeline registers (PC, IF/ID, ID/EX) by producing hold, flush and PC-redirect signals. The hazard sources are taken jumps from EX, load-use hazards from ID, multi-cycle MUL/DIV ops, and instruction-fetch wait. It sits beside the datapath and drives the hold/flush inputs of every stage register.

## Interface
- ADDR_W, 32, PC/jump address width
- LU_BUBBLES, 1, load-use bubble cycles inserted (legal 1..7)
- PERF_W, 32, performance counter width (used only with PIPE_CTRL_PERF_EN)

- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- jump_en_i  in  1  EX resolved a taken branch/jump this cycle
- jump_addr_i  in  ADDR_W  target of that jump
- ld_use_i  in  1  ID instruction depends on load currently in EX
- mdu_start_i  in  1  EX issues multi-cycle MUL/DIV
- mdu_done_i  in  1  MUL/DIV result valid this cycle
- ifetch_ready_i  in  1  instruction memory returns valid instruction this cycle
- hold_pc_o  out  1  PC keeps value
- hold_if_id_o  out  1  IF/ID keeps contents
- hold_id_ex_o  out  1  ID/EX keeps contents
- flush_if_id_o  out  1  IF/ID loads INST_NOP
- flush_id_ex_o  out  1  ID/EX loads NOP bubble
- redirect_o  out  1  PC loads redirect_addr_o
- redirect_addr_o  out  ADDR_W  redirect target
- stall_cnt_o, flush_cnt_o  out  PERF_W  perf counters (only with PIPE_CTRL_PERF_EN)

## Operation
- States: RUN, LU_STALL, MDU_BUSY, JMP_PEND. Outputs are Mealy: a function of state plus the current inputs. Default for every output is 0.
- Registered state:
  - state
  - bubble counter lu_cnt (3 bits)
  - jmp_addr_q (ADDR_W)
- Reset (rst=1 at an edge) returns to RUN with lu_cnt=0 and jmp_addr_q=0. While rst=1, all outputs are forced to 0.
- RUN, in priority order:
  1. jump_en_i: assert redirect_o with redirect_addr_o=jump_addr_i, plus flush_if_id_o and flush_id_ex_o. If ifetch_ready_i=0, latch jump_addr_i into jmp_addr_q and go to JMP_PEND. Otherwise stay in RUN.
  2. mdu_start_i with mdu_done_i=0: assert hold_pc_o, hold_if_id_o and hold_id_ex_o, then go to MDU_BUSY. If mdu_done_i=1 in the same cycle, no hold is applied.
  3. ld_use_i: assert hold_pc_o, hold_if_id_o and flush_id_ex_o. If LU_BUBBLES>1, load lu_cnt=LU_BUBBLES-2 and go to LU_STALL.
  4. ifetch_ready_i=0: assert hold_pc_o and flush_if_id_o. No state change.
- LU_STALL:
  - Each cycle asserts the same outputs as the load-use case in RUN.
  - If lu_cnt=0, go to RUN; otherwise decrement lu_cnt.
  - jump_en_i aborts the stall and is handled exactly as in RUN (RUN or JMP_PEND).
- MDU_BUSY:
  - Hold all three registers every cycle.
  - On mdu_done_i=1, deassert all holds in that same cycle and go to RUN.
  - jump_en_i, ld_use_i and ifetch_ready_i are ignored (EX is frozen).
- JMP_PEND:
  - Each cycle: redirect_o=1, redirect_addr_o=jmp_addr_q, flush_if_id_o=1.
  - On ifetch_ready_i=1, go to RUN; that cycle still outputs the redirect.
  - Further jump_en_i is ignored (EX holds a bubble).
- hold_X and flush_X are never both asserted for the same register.

## Timing
- Zero-cycle response: hazard inputs affect outputs in the same cycle. No combinational path runs from outputs back to inputs.
- Load-use inserts exactly LU_BUBBLES bubbles. IF/ID and PC are frozen for LU_BUBBLES cycles.
- MDU stall length = cycles from start to done. The hold drops in the done cycle, so EX captures the result there.
- Jump penalty is 2 flushed instructions, plus one extra IF/ID flush per fetch-wait cycle in JMP_PEND.
- Simultaneous jump_en_i and ld_use_i: the jump wins and no bubble counting starts.
- Reset mid-MDU_BUSY or mid-JMP_PEND: the next cycle is RUN with all outputs 0. The pending target is discarded.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt_o increments on every cycle with hold_pc_o=1.
  - flush_cnt_o increments on every cycle with flush_id_ex_o=1 or flush_if_id_o=1.
  - Both counters clear on rst and wrap at 2^PERF_W.
- Not defined: both ports and both counters are absent. Remaining behaviour is identical.

## Structure
- Shared define header:
  - state encodings PIPE_CTRL_RUN=2'd0, LU_STALL=2'd1, MDU_BUSY=2'd2, JMP_PEND=2'd3
  - INST_NOP (existing)
- Sub-module pipe_perf_cnt: a PERF_W saturating-free counter with sync clear. It is instantiated twice under PIPE_CTRL_PERF_EN.

## Test plan
- Reset: drive rst=1 for 2 cycles with all inputs active -> all outputs 0. After release, state is RUN.
- Load-use, LU_BUBBLES=3: ld_use_i pulse -> hold_pc_o, hold_if_id_o and flush_id_ex_o high for exactly 3 cycles, then low.
- MDU: start at cycle 0, done at cycle 5 -> holds high on cycles 0-4 and low on cycle 5. A jump_en_i at cycle 2 is ignored.
- Jump during fetch wait: jump_en_i with addr 0x0000_0100 and ifetch_ready_i=0 for 3 cycles -> redirect_o=1 with addr 0x100 for 4 cycles, and flush_if_id_o=1 throughout.
- Simultaneous jump_en_i and ld_use_i in RUN -> redirect plus both flushes, no hold, state stays RUN.
- PIPE_CTRL_PERF_EN: after the load-use test, stall_cnt_o=3 and flush_cnt_o=3. The counters wrap from 2^PERF_W-1 to 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared state encodings and constants for the pipeline controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PIPE_CTRL_RUN      = 2'd0,
        PIPE_CTRL_LU_STALL = 2'd1,
        PIPE_CTRL_MDU_BUSY = 2'd2,
        PIPE_CTRL_JMP_PEND = 2'd3
    } pipe_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int LU_CNT_W = 3;

    // Reload value for the bubble counter: the RUN cycle is the first bubble
    // and the cycle that sees a zero count is the last one.
    function automatic logic [LU_CNT_W-1:0] lu_reload(input int bubbles);
        logic [LU_CNT_W-1:0] val;
        val = '0;
        if (bubbles > 1) begin
            val = LU_CNT_W'(bubbles - 2);
        end
        return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
// ============================================================================
// Module  : pipe_perf_cnt
// Brief   : Free-running wrap-around event counter with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Brief   : Hold/flush/redirect sequencing for the 5-stage pipeline front end.
//           Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LU_BUBBLES = 1,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ld_use_i,
    input  logic              mdu_start_i,
    input  logic              mdu_done_i,
    input  logic              ifetch_ready_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              redirect_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o,
`endif
    output logic [ADDR_W-1:0] redirect_addr_o
);

    localparam logic                LU_MULTI  = (LU_BUBBLES > 1);
    localparam logic [LU_CNT_W-1:0] LU_RELOAD = lu_reload(LU_BUBBLES);

    pipe_state_e         state;
    logic [LU_CNT_W-1:0] lu_cnt;
    logic [ADDR_W-1:0]   jmp_addr_q;

    logic jump_take;
    logic mdu_stall;

    // A jump is only honoured while EX is live; in MDU_BUSY/JMP_PEND it is a bubble.
    assign jump_take = jump_en_i &&
                       ((state == PIPE_CTRL_RUN) || (state == PIPE_CTRL_LU_STALL));
    assign mdu_stall = mdu_start_i && !mdu_done_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PIPE_CTRL_RUN;
            lu_cnt     <= '0;
            jmp_addr_q <= '0;
        end else begin
            case (state)
                PIPE_CTRL_RUN: begin
                    if (jump_take) begin
                        if (!ifetch_ready_i) begin
                            jmp_addr_q <= jump_addr_i;
                            state      <= PIPE_CTRL_JMP_PEND;
                        end
                    end else if (mdu_stall) begin
                        state <= PIPE_CTRL_MDU_BUSY;
                    end else if (ld_use_i && LU_MULTI) begin
                        lu_cnt <= LU_RELOAD;
                        state  <= PIPE_CTRL_LU_STALL;
                    end
                end
                PIPE_CTRL_LU_STALL: begin
                    if (jump_take) begin
                        if (!ifetch_ready_i) begin
                            jmp_addr_q <= jump_addr_i;
                            state      <= PIPE_CTRL_JMP_PEND;
                        end else begin
                            state <= PIPE_CTRL_RUN;
                        end
                    end else if (lu_cnt == '0) begin
                        state <= PIPE_CTRL_RUN;
                    end else begin
                        lu_cnt <= lu_cnt - LU_CNT_W'(1);
                    end
                end
                PIPE_CTRL_MDU_BUSY: begin
                    if (mdu_done_i) begin
                        state <= PIPE_CTRL_RUN;
                    end
                end
                PIPE_CTRL_JMP_PEND: begin
                    if (ifetch_ready_i) begin
                        state <= PIPE_CTRL_RUN;
                    end
                end
                default: state <= PIPE_CTRL_RUN;
            endcase
        end
    end

    always_comb begin
        hold_pc_o       = 1'b0;
        hold_if_id_o    = 1'b0;
        hold_id_ex_o    = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        redirect_o      = 1'b0;
        redirect_addr_o = '0;
        if (!rst) begin
            case (state)
                PIPE_CTRL_RUN, PIPE_CTRL_LU_STALL: begin
                    if (jump_take) begin
                        redirect_o      = 1'b1;
                        redirect_addr_o = jump_addr_i;
                        flush_if_id_o   = 1'b1;
                        flush_id_ex_o   = 1'b1;
                    end else if ((state == PIPE_CTRL_RUN) && mdu_stall) begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = 1'b1;
                        hold_id_ex_o = 1'b1;
                    end else if ((state == PIPE_CTRL_LU_STALL) || ld_use_i) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (!ifetch_ready_i) begin
                        hold_pc_o     = 1'b1;
                        flush_if_id_o = 1'b1;
                    end
                end
                PIPE_CTRL_MDU_BUSY: begin
                    // Holds drop in the done cycle so EX captures the result.
                    if (!mdu_done_i) begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = 1'b1;
                        hold_id_ex_o = 1'b1;
                    end
                end
                PIPE_CTRL_JMP_PEND: begin
                    redirect_o      = 1'b1;
                    redirect_addr_o = jmp_addr_q;
                    flush_if_id_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt #(
        .WIDTH (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hold_pc_o),
        .count (stall_cnt_o)
    );

    pipe_perf_cnt #(
        .WIDTH (PERF_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_if_id_o || flush_id_ex_o),
        .count (flush_cnt_o)
    );
`endif

endmodule

`default_nettype wire
